shifter_operand_fetch: RTL and testbench

//  Stage directly upstream of the barrel shifter. Accepts a data-processing instruction,

---
 rtl/shifter_operand_fetch_pkg.sv | 55 +++++
 rtl/shifter_operand_fetch_operand2_field_decode.sv | 58 +++++
 rtl/shifter_operand_fetch.sv | 149 ++++++++++++++
 tb/tb_shifter_operand_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_operand_fetch_pkg.sv
// Shared definitions for the shifter operand fetch stage and the barrel shifter
// that consumes its bundle: shift op codes, operand forms, FSM states and the
// decoded operand-2 record.
package shifter_operand_fetch_pkg;

    // Op codes seen by the barrel shifter on its op_select input
    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } shift_op_e;

    // Shifter operand encodings of a data-processing instruction
    typedef enum logic [1:0] {
        FORM_IMM32     = 2'd0,
        FORM_IMM_SHIFT = 2'd1,
        FORM_REG_SHIFT = 2'd2
    } operand_form_e;

    // Fetch sequencer states; the 32-bit immediate form needs no register read
    // and lands directly in ST_OUT from the accept cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_RM = 2'd1,
        ST_RD_RS = 2'd2,
        ST_OUT   = 2'd3
    } fetch_state_e;

    // PC read-ahead seen by an instruction that names R15 as Rm
    localparam logic [31:0] PC_OFFSET_IMM_DEF = 32'd8;
    localparam logic [31:0] PC_OFFSET_REG_DEF = 32'd12;

    // Everything the fetch stage needs from the instruction word
    typedef struct packed {
        operand_form_e form;
        logic [3:0]    rm;
        logic [3:0]    rs;
        shift_op_e     op;
        logic [31:0]   shift_value;
        logic [31:0]   imm_data;
    } operand2_decode_t;

    // Map the two-bit shift type field onto the shifter op code
    function automatic shift_op_e shift_type_to_op(input logic [1:0] shift_type);
        case (shift_type)
            2'd0:    return OP_LSL;
            2'd1:    return OP_LSR;
            2'd2:    return OP_ASR;
            default: return OP_ROR;
        endcase
    endfunction

endpackage

// File: rtl/shifter_operand_fetch_operand2_field_decode.sv
// Combinational decode of the shifter operand field of a data-processing
// instruction. Produces the operand form, register indices and the final
// op/shift amount for the immediate forms, including the "amount 0" remaps.
module operand2_field_decode
    import shifter_operand_fetch_pkg::*;
(
    input  logic [31:0]      instr,
    output operand2_decode_t dec
);

    logic [4:0] shift_imm;
    logic [1:0] shift_type;
    logic       unused_instr_bits;

    assign shift_imm         = instr[11:7];
    assign shift_type        = instr[6:5];
    assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

    // Select the operand form and resolve op code and shift amount
    always_comb begin
        dec = '{form:        FORM_IMM32,
                rm:          instr[3:0],
                rs:          instr[11:8],
                op:          OP_LSL,
                shift_value: 32'd0,
                imm_data:    32'd0};
        if (instr[25]) begin
            // imm8 rotated right by twice the 4-bit rotate field
            dec.form        = FORM_IMM32;
            dec.op          = OP_ROR;
            dec.shift_value = {27'd0, instr[11:8], 1'b0};
            dec.imm_data    = {24'd0, instr[7:0]};
        end else if (!instr[4]) begin
            dec.form        = FORM_IMM_SHIFT;
            dec.op          = shift_type_to_op(shift_type);
            dec.shift_value = {27'd0, shift_imm};
            if (shift_imm == 5'd0) begin
                case (shift_type)
                    2'd0: dec.shift_value = 32'd0;
                    2'd1: dec.shift_value = 32'd32;
                    2'd2: dec.shift_value = 32'd32;
                    default: begin
                        // ROR #0 encodes RRX; a zero amount would make the
                        // shifter pass C through instead of rotating it in
                        dec.op          = OP_RRX;
                        dec.shift_value = 32'd1;
                    end
                endcase
            end
        end else begin
            // Amount comes from Rs[7:0] later; op is taken as-is
            dec.form        = FORM_REG_SHIFT;
            dec.op          = shift_type_to_op(shift_type);
            dec.shift_value = 32'd0;
        end
    end

endmodule

// File: rtl/shifter_operand_fetch.sv
// Operand fetch stage in front of the barrel shifter. Decodes the shifter
// operand, reads Rm and (for register shifts) Rs through one synchronous
// register-file port, and presents a registered bundle with valid/ready.
module shifter_operand_fetch
    import shifter_operand_fetch_pkg::*;
#(
    parameter logic [31:0] PC_OFFSET_IMM = PC_OFFSET_IMM_DEF,
    parameter logic [31:0] PC_OFFSET_REG = PC_OFFSET_REG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        in_carry,
    output logic [3:0]  out_rf_addr,
    input  logic [31:0] in_rf_data,
    output logic        out_valid,
    input  logic        in_out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_shift_value,
    output logic [2:0]  out_op_select,
    output logic        out_carry
);

    fetch_state_e     state;
    operand2_decode_t dec;
    logic             accept;
    logic [3:0]       rf_addr_q;
    logic [31:0]      rm_value;

    // Instruction fields captured on accept
    operand_form_e    form_p0;
    shift_op_e        op_p0;
    logic [31:0]      shift_p0;
    logic [3:0]       rs_p0;
    logic [31:0]      pc_p0;
    logic             rm_is_pc_p0;

    // R15 as Rm reads the instruction address plus the pipeline read-ahead
    function automatic logic [31:0] pc_operand(input logic [31:0] pc,
                                               input operand_form_e form);
        return pc + ((form == FORM_REG_SHIFT) ? PC_OFFSET_REG : PC_OFFSET_IMM);
    endfunction

    operand2_field_decode u_decode (
        .instr (in_instr),
        .dec   (dec)
    );

    // A new instruction may enter when idle or when the held bundle leaves now
    assign in_ready = rst_n && !in_flush &&
                      ((state == ST_IDLE) || ((state == ST_OUT) && in_out_ready));
    assign accept   = in_valid && in_ready;

    // Register-file address: Rm in the accept cycle, Rs in the following
    // cycle for register shifts, otherwise the last address driven
    always_comb begin
        out_rf_addr = rf_addr_q;
        if (accept && (dec.form != FORM_IMM32)) begin
            out_rf_addr = dec.rm;
        end else if ((state == ST_RD_RM) && (form_p0 == FORM_REG_SHIFT)) begin
            out_rf_addr = rs_p0;
        end
    end

    assign rm_value = rm_is_pc_p0 ? pc_p0 : in_rf_data;

    // Capture the decoded fields of each accepted instruction
    always_ff @(posedge clk) begin
        if (accept) begin
            form_p0     <= dec.form;
            op_p0       <= dec.op;
            shift_p0    <= dec.shift_value;
            rs_p0       <= dec.rs;
            pc_p0       <= pc_operand(in_pc, dec.form);
            rm_is_pc_p0 <= (dec.rm == 4'd15);
        end
    end

    // Fetch sequencer and registered output bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            out_valid       <= 1'b0;
            out_data        <= 32'd0;
            out_shift_value <= 32'd0;
            out_op_select   <= OP_LSL;
            out_carry       <= 1'b0;
            rf_addr_q       <= 4'd0;
        end else begin
            rf_addr_q <= out_rf_addr;
            if (in_flush) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
            end else if (accept) begin
                // ---- accept: immediate form completes, others start reading Rm
                if (dec.form == FORM_IMM32) begin
                    out_data        <= dec.imm_data;
                    out_shift_value <= dec.shift_value;
                    out_op_select   <= OP_ROR;
                    out_carry       <= in_carry;
                    out_valid       <= 1'b1;
                    state           <= ST_OUT;
                end else begin
                    out_valid <= 1'b0;
                    state     <= ST_RD_RM;
                end
            end else begin
                case (state)
                    ST_RD_RM: begin
                        // ---- Rm data returns; immediate shifts are complete
                        out_data <= rm_value;
                        if (form_p0 == FORM_IMM_SHIFT) begin
                            out_shift_value <= shift_p0;
                            out_op_select   <= op_p0;
                            out_carry       <= in_carry;
                            out_valid       <= 1'b1;
                            state           <= ST_OUT;
                        end else begin
                            state <= ST_RD_RS;
                        end
                    end
                    ST_RD_RS: begin
                        // ---- Rs data returns; only its low byte is an amount
                        out_shift_value <= {24'd0, in_rf_data[7:0]};
                        out_op_select   <= op_p0;
                        out_carry       <= in_carry;
                        out_valid       <= 1'b1;
                        state           <= ST_OUT;
                    end
                    ST_OUT: begin
                        // ---- bundle held until the shifter takes it
                        if (in_out_ready) begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shifter_operand_fetch.sv
// Bench for shifter_operand_fetch: directed cases plus randomized traffic,
// a register-file model, and a scoreboard fed by an operand-2 reference model.
module tb_shifter_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        in_carry;
    logic [3:0]  out_rf_addr;
    logic [31:0] in_rf_data = 32'd0;
    logic        out_valid;
    logic        in_out_ready;
    logic [31:0] out_data;
    logic [31:0] out_shift_value;
    logic [2:0]  out_op_select;
    logic        out_carry;

    typedef struct {
        logic [31:0] data;
        logic [31:0] shift;
        logic [2:0]  op;
        int          carry_cyc;
        int          vcyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs [16];
    logic        carry_log [8192];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    bit          timeout_flag = 0;

    always #5 clk = ~clk;

    shifter_operand_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_flush        (in_flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .in_carry        (in_carry),
        .out_rf_addr     (out_rf_addr),
        .in_rf_data      (in_rf_data),
        .out_valid       (out_valid),
        .in_out_ready    (in_out_ready),
        .out_data        (out_data),
        .out_shift_value (out_shift_value),
        .out_op_select   (out_op_select),
        .out_carry       (out_carry)
    );

    // Synchronous read port: data for an address appears the next cycle
    always @(posedge clk) in_rf_data <= regs[out_rf_addr];

    // Random carry flag and shifter-ready pattern
    initial begin
        in_carry = 1'b0;
        in_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            in_carry = 1'($urandom);
            case (ready_mode)
                0:       in_out_ready = 1'b1;
                1:       in_out_ready = ($urandom_range(0, 3) != 0);
                default: in_out_ready = 1'b0;
            endcase
        end
    end

    // Reference: what the shifter must receive for one instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input int acc);
        exp_t        e;
        logic [3:0]  rm;
        logic [3:0]  rs;
        int          amt;
        int          ty;
        int          lat;
        rm  = ins[3:0];
        rs  = ins[11:8];
        amt = int'(ins[11:7]);
        ty  = int'(ins[6:5]);
        if (ins[25]) begin
            e.data  = {24'd0, ins[7:0]};
            e.shift = 32'(ins[11:8]) * 2;
            e.op    = 3'd3;
            lat     = 1;
        end else if (!ins[4]) begin
            e.data  = (rm == 4'd15) ? pc + 32'd8 : regs[rm];
            e.op    = 3'(ty);
            e.shift = 32'(amt);
            if (amt == 0) begin
                if (ty == 1 || ty == 2) e.shift = 32'd32;
                if (ty == 3) begin
                    e.op    = 3'd4;
                    e.shift = 32'd1;
                end
            end
            lat = 2;
        end else begin
            e.data  = (rm == 4'd15) ? pc + 32'd12 : regs[rm];
            e.shift = regs[rs] % 256;
            e.op    = 3'(ty);
            lat     = 3;
        end
        e.vcyc      = acc + lat;
        e.carry_cyc = acc + lat - 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampling mid-cycle
    initial begin
        bit          head_seen = 0;
        bit          prev_hold = 0;
        bit          timeout_reported = 0;
        bit          presented;
        bit          exp_ready;
        int          rs_chk_cyc = -1;
        logic [3:0]  rs_exp = 4'd0;
        logic [31:0] p_data = 0, p_shift = 0;
        logic [2:0]  p_op = 0;
        logic        p_carry = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            carry_log[cyc % 8192] = in_carry;
            if (timeout_flag && !timeout_reported) begin
                timeout_reported = 1;
                checks++;
                errors++;
                $display("FAIL issue_timeout actual=not_accepted expected=accepted cycle=%0d", cyc);
            end
            if (!rst_n) begin
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_data", out_data, 32'd0);
                chk("rst_shift", out_shift_value, 32'd0);
                chk("rst_op", 32'(out_op_select), 32'd0);
                chk("rst_carry", 32'(out_carry), 32'd0);
                chk("rst_rf_addr", 32'(out_rf_addr), 32'd0);
                q.delete();
                head_seen  = 0;
                prev_hold  = 0;
                rs_chk_cyc = -1;
            end else begin
                if (rs_chk_cyc == cyc) chk("rf_addr_rs", 32'(out_rf_addr), 32'(rs_exp));
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", out_data, p_data);
                    chk("hold_shift", out_shift_value, p_shift);
                    chk("hold_op", 32'(out_op_select), 32'(p_op));
                    chk("hold_carry", 32'(out_carry), 32'(p_carry));
                end
                presented = out_valid && in_out_ready;
                exp_ready = !in_flush && (q.size() == 0 || presented);
                chk("in_ready", 32'(in_ready), 32'(exp_ready));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", 32'(out_valid), 32'd0);
                    end else if (!head_seen) begin
                        head_seen = 1;
                        chk("latency", cyc, q[0].vcyc);
                        chk("data", out_data, q[0].data);
                        chk("shift", out_shift_value, q[0].shift);
                        chk("op", 32'(out_op_select), 32'(q[0].op));
                        chk("carry", 32'(out_carry), 32'(carry_log[q[0].carry_cyc % 8192]));
                    end
                end else if (q.size() > 0 && !head_seen && cyc >= q[0].vcyc) begin
                    chk("valid_missing", 32'(out_valid), 32'd1);
                    void'(q.pop_front());
                end
                prev_hold = out_valid && !in_out_ready && !in_flush;
                p_data    = out_data;
                p_shift   = out_shift_value;
                p_op      = out_op_select;
                p_carry   = out_carry;
                if (in_flush) begin
                    q.delete();
                    head_seen = 0;
                end else if (presented && q.size() > 0 && head_seen) begin
                    void'(q.pop_front());
                    head_seen = 0;
                end
                if (in_valid && exp_ready) begin
                    e = model(in_instr, in_pc, cyc);
                    q.push_back(e);
                    if (!in_instr[25]) chk("rf_addr_rm", 32'(out_rf_addr), 32'(in_instr[3:0]));
                    if (!in_instr[25] && in_instr[4]) begin
                        rs_chk_cyc = cyc + 1;
                        rs_exp     = in_instr[11:8];
                    end
                end
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded)
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                timeout_flag = 1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [31:0] w;
        int          form;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[1] = 32'h0000_0001;
        regs[2] = 32'h8000_0001;
        regs[3] = 32'h0000_0104;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 32-bit immediate, immediate shifts, register shift, R15 operands
        issue(32'hE3A004FF, 32'h0000_2000); idle(2);
        issue(32'hE1A00022, 32'h0000_2004); idle(3);
        issue(32'hE1A00062, 32'h0000_2008); idle(3);
        issue(32'hE1A00311, 32'h0000_200C); idle(4);
        issue(32'hE1A0000F, 32'h0000_1000); idle(3);
        issue(32'hE1A0031F, 32'h0000_1000); idle(4);

        // Backpressure, then release together with a new instruction
        @(negedge clk) ready_mode = 2;
        issue(32'hE3A00C12, 32'h0000_3000);
        idle(5);
        @(negedge clk) ready_mode = 0;
        issue(32'hE3A00A34, 32'h0000_3004);
        issue(32'hE3A00156, 32'h0000_3008);
        idle(3);

        // Flush while Rs is being read
        issue(32'hE1A00311, 32'h0000_4000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 in_flush = 1'b1;
        @(posedge clk); #1 in_flush = 1'b0;
        idle(4);

        // Flush coinciding with a valid instruction
        @(posedge clk); #1;
        in_flush = 1'b1; in_valid = 1'b1; in_instr = 32'hE3A004FF;
        @(posedge clk); #1;
        in_flush = 1'b0; in_valid = 1'b0;
        idle(3);

        // Reset while Rm is being read
        issue(32'hE1A00022, 32'h0000_5000);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Randomized traffic with random shifter stalls
        @(negedge clk) ready_mode = 1;
        for (int t = 0; t < 120; t++) begin
            w    = $urandom;
            form = $urandom_range(0, 2);
            if (form == 0) w[25] = 1'b1;
            else begin
                w[25] = 1'b0;
                w[4]  = (form == 2);
                if (form == 2) w[7] = 1'b0;
                if ($urandom_range(0, 4) == 0) w[3:0] = 4'hF;
                if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
            end
            issue(w, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        idle(1);
        @(negedge clk) ready_mode = 0;
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
